// File: rtl/div_seq.sv
// Multi-cycle radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Optional macro DIV_EARLY_OUT_EN adds a |rs1| < |rs2| shortcut at accept.
module div_seq #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            flush,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t          state;
    logic [XLEN-1:0] rem_q, quot_q, dvsr_q, res_pend;
    logic [CNT_W-1:0] cnt;
    logic            quot_neg, rem_neg, op_rem;

    logic            sgn, div0, ovf, early;
    logic [XLEN-1:0] mag1, mag2, spec_res, q_fix, r_fix;
    logic [XLEN:0]   shifted, diff;
    logic            ge;

    assign busy = (state == CALC) || (state == FIX);

    // Accept-time decode: magnitudes and the shortcut cases
    assign sgn  = ~op[0];
    assign mag1 = (sgn && rs1[XLEN-1]) ? -rs1 : rs1;
    assign mag2 = (sgn && rs2[XLEN-1]) ? -rs2 : rs2;
    assign div0 = (rs2 == '0);
    assign ovf  = sgn && (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == '1);
`ifdef DIV_EARLY_OUT_EN
    assign early = !div0 && (mag1 < mag2);
`else
    assign early = 1'b0;
`endif

    always_comb begin
        spec_res = '0;
        if (div0)
            spec_res = op[1] ? rs1 : '1;
        else if (ovf)
            spec_res = op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
        else if (early)
            spec_res = op[1] ? rs1 : '0;
    end

    // One restoring step: partial remainder never exceeds 2*divisor, so the
    // MSB of the XLEN+1 bit difference is a reliable borrow.
    assign shifted = {rem_q, quot_q[XLEN-1]};
    assign diff    = shifted - {1'b0, dvsr_q};
    assign ge      = ~diff[XLEN];

    assign q_fix = quot_neg ? -quot_q : quot_q;
    assign r_fix = rem_neg  ? -rem_q  : rem_q;

    // result is committed only in DONE so a flush anywhere leaves it intact
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            done     <= 1'b0;
            result   <= '0;
            rem_q    <= '0;
            quot_q   <= '0;
            dvsr_q   <= '0;
            res_pend <= '0;
            cnt      <= '0;
            quot_neg <= 1'b0;
            rem_neg  <= 1'b0;
            op_rem   <= 1'b0;
        end else if (flush) begin
            state <= IDLE;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_rem <= op[1];
                        if (div0 || ovf || early) begin
                            res_pend <= spec_res;
                            state    <= DONE;
                        end else begin
                            rem_q    <= '0;
                            quot_q   <= mag1;
                            dvsr_q   <= mag2;
                            quot_neg <= sgn & (rs1[XLEN-1] ^ rs2[XLEN-1]);
                            rem_neg  <= sgn & rs1[XLEN-1];
                            cnt      <= CNT_W'(XLEN - 1);
                            state    <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem_q  <= ge ? diff[XLEN-1:0] : shifted[XLEN-1:0];
                    quot_q <= {quot_q[XLEN-2:0], ge};
                    cnt    <= cnt - 1'b1;
                    if (cnt == '0)
                        state <= FIX;
                end
                FIX: begin
                    res_pend <= op_rem ? r_fix : q_fix;
                    state    <= DONE;
                end
                DONE: begin
                    done   <= 1'b1;
                    result <= res_pend;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq.sv
// Bench for div_seq: vector table plus random ops against a behavioural model,
// scoreboard on done, and hand sequences for flush, busy-start and reset.
module tb_div_seq;
    localparam int XLEN = 32;

    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, flush = 1'b0;
    logic [1:0]  op = '0;
    logic [31:0] rs1 = '0, rs2 = '0;
    logic        busy, done;
    logic [31:0] result;

    div_seq #(.XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .flush(flush), .op(op),
        .rs1(rs1), .rs2(rs2), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [1:0] op; logic [31:0] a, b, exp; } vec_t;
    typedef struct { logic [31:0] exp; int lat; int acc; int busy0; } sb_t;

    sb_t sb[$];
    sb_t mon_e;
    int  ncmp = 0, nerr = 0, busy_cnt = 0;
    vec_t tv[18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int exp_lat(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic s;
        logic [31:0] m1, m2;
        s  = ~o[0];
        m1 = (s && a[31]) ? -a : a;
        m2 = (s && b[31]) ? -b : b;
        if (b == 0 || (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
`ifdef DIV_EARLY_OUT_EN
        if (m1 < m2) return 1;
`endif
        if (m1 == m2) return XLEN + 2;
        return XLEN + 2;
    endfunction

    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        if (b == 0) return o[1] ? a : 32'hFFFF_FFFF;
        if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return o[1] ? 32'h0 : 32'h8000_0000;
        if (!o[0]) return o[1] ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
        return o[1] ? a % b : a / b;
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (busy) busy_cnt++;
            if (done) begin
                if (sb.size() == 0) begin
                    ncmp++; nerr++;
                    $display("FAIL spurious_done: got done=1 result=%h expected no done", result);
                end else begin
                    mon_e = sb.pop_front();
                    chk("result", result, mon_e.exp);
                    chk("latency", 32'(cyc - mon_e.acc), 32'(mon_e.lat));
                    chk("busy_cycles", 32'(busy_cnt - mon_e.busy0), (mon_e.lat == 1) ? 32'd0 : 32'(XLEN + 1));
                end
            end
        end
    end

    // mode 1: pulse start mid-CALC with other operands; mode 2: hold start two edges
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] e, input int mode);
        @(negedge clk);
        start = 1'b1; op = o; rs1 = a; rs2 = b;
        @(posedge clk); #1;
        sb.push_back('{e, exp_lat(o, a, b), cyc, busy_cnt});
        if (mode == 2) begin @(posedge clk); #1; end
        start = 1'b0;
        if (mode == 1) begin
            repeat (5) @(posedge clk);
            #1 start = 1'b1; op = ~o; rs1 = 32'h1234; rs2 = 32'd3;
            @(posedge clk); #1 start = 1'b0;
        end
        for (int i = 0; i < 60 && sb.size() != 0; i++) begin
            @(posedge clk); #2;
        end
        if (sb.size() != 0) begin
            ncmp++; nerr++;
            $display("FAIL timeout: got no done within bound, expected result %h", e);
            sb.delete();
        end
        @(negedge clk); #1;
        chk("done_pulse_width", {31'd0, done}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra, rb;

        tv[0]  = '{2'b00, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD};
        tv[1]  = '{2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF};
        tv[2]  = '{2'b11, 32'hFFFF_FFF9, 32'd2,         32'd1};
        tv[3]  = '{2'b01, 32'hFFFF_FFF9, 32'd2,         32'h7FFF_FFFC};
        tv[4]  = '{2'b00, 32'd5,         32'd0,         32'hFFFF_FFFF};
        tv[5]  = '{2'b10, 32'd5,         32'd0,         32'd5};
        tv[6]  = '{2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
        tv[7]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0};
        tv[8]  = '{2'b11, 32'd3,         32'd10,        32'd3};
        tv[9]  = '{2'b00, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD};
        tv[10] = '{2'b10, 32'd7,         32'hFFFF_FFFE, 32'd1};
        tv[11] = '{2'b01, 32'd100,       32'd7,         32'd14};
        tv[12] = '{2'b10, 32'hFFFF_FFFD, 32'd10,        32'hFFFF_FFFD};
        tv[13] = '{2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0};
        tv[14] = '{2'b11, 32'h1234_5678, 32'd0,         32'h1234_5678};
        tv[15] = '{2'b00, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF};
        tv[16] = '{2'b10, 32'h8000_0000, 32'd3,         32'hFFFF_FFFE};
        tv[17] = '{2'b00, 32'h8000_0000, 32'd3,         32'hD555_5556};

        #12;
        chk("reset_busy",   {31'd0, busy}, 32'd0);
        chk("reset_done",   {31'd0, done}, 32'd0);
        chk("reset_result", result,        32'd0);
        @(negedge clk) rst_n = 1'b1;

        foreach (tv[i]) issue(tv[i].op, tv[i].a, tv[i].b, tv[i].exp, 0);

        for (int i = 0; i < 16; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            issue(ro, ra, rb, model(ro, ra, rb), 0);
        end

        issue(2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1);
        issue(2'b00, 32'd5, 32'd0, 32'hFFFF_FFFF, 2);
        issue(2'b01, 32'd100, 32'd7, 32'd14, 2);

        // flush on the tenth CALC cycle
        issue(2'b10, 32'd5, 32'd0, 32'd5, 0);
        @(negedge clk);
        start = 1'b1; op = 2'b01; rs1 = 32'd100; rs2 = 32'd7;
        @(posedge clk); #1 start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk) flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        chk("flush_busy",   {31'd0, busy}, 32'd0);
        chk("flush_done",   {31'd0, done}, 32'd0);
        chk("flush_result", result,        32'd5);
        repeat (40) @(negedge clk);
        chk("flush_result_hold", result, 32'd5);
        issue(2'b01, 32'd100, 32'd7, 32'd14, 0);

        // flush beats start in IDLE
        @(negedge clk);
        start = 1'b1; flush = 1'b1; op = 2'b00; rs1 = 32'd9; rs2 = 32'd0;
        @(posedge clk); #1 start = 1'b0; flush = 1'b0;
        chk("flush_start_busy", {31'd0, busy}, 32'd0);
        repeat (40) @(negedge clk);
        chk("flush_start_result", result, 32'd14);

        // asynchronous reset mid-CALC
        @(negedge clk);
        start = 1'b1; op = 2'b01; rs1 = 32'd100; rs2 = 32'd7;
        @(posedge clk); #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_busy",   {31'd0, busy}, 32'd0);
        chk("arst_done",   {31'd0, done}, 32'd0);
        chk("arst_result", result,        32'd0);
        @(negedge clk) rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("arst_result_hold", result, 32'd0);
        issue(2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0);

        $display("== %0d vectors applied, %0d miscompares ==", ncmp, nerr);
        $finish;
    end
endmodule
